// File: rtl/wave_shaper_mix_if.sv
// Bus between the voice controller and the wave shaper / mixer.
// Optional WAVE_SHAPER_PWM_EN adds a per-voice pulse_width lane.
interface wave_shaper_mix_if #(
    parameter int W          = 8,
    parameter int NUM_VOICES = 4
);
    // sample_req is honoured only while busy is low; each accepted request
    // yields exactly one sample_valid pulse, with mix_out valid in that cycle.
    logic                    sample_req;
    logic [NUM_VOICES*W-1:0] phase_in;
    logic [NUM_VOICES*2-1:0] wave_form;
`ifdef WAVE_SHAPER_PWM_EN
    logic [NUM_VOICES*W-1:0] pulse_width;
`endif
    logic                    busy;
    logic                    sample_valid;
    logic [W-1:0]            mix_out;

`ifdef WAVE_SHAPER_PWM_EN
    modport master (output sample_req, phase_in, wave_form, pulse_width,
                    input  busy, sample_valid, mix_out);
    modport slave  (input  sample_req, phase_in, wave_form, pulse_width,
                    output busy, sample_valid, mix_out);
`else
    modport master (output sample_req, phase_in, wave_form,
                    input  busy, sample_valid, mix_out);
    modport slave  (input  sample_req, phase_in, wave_form,
                    output busy, sample_valid, mix_out);
`endif
endinterface

// File: rtl/wave_shaper_mix.sv
// Shapes NUM_VOICES phase words (off/square/saw/triangle) one per cycle and averages them.
// WAVE_SHAPER_PWM_EN selects a per-voice square threshold instead of a fixed 50% duty.
module wave_shaper_mix #(
    parameter int W          = 8,
    parameter int NUM_VOICES = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    wave_shaper_mix_if.slave        bus,
    output logic [1:0]              state_dbg_o
);
    localparam int LOG_V = $clog2(NUM_VOICES);
    localparam int IDW   = (LOG_V > 0) ? LOG_V : 1;
    localparam int ACW   = W + LOG_V;
    localparam logic [W-1:0]   HALF = W'(1) << (W - 1);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHAPE, OUT} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] idx_q, idx_d;
    logic [ACW-1:0] acc_q, acc_d;
    logic [W-1:0]   mix_q, mix_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   phase_snap_q [NUM_VOICES];
    logic [W-1:0]   phase_snap_d [NUM_VOICES];
    logic [W-1:0]   prev_phase_q [NUM_VOICES];
    logic [W-1:0]   prev_phase_d [NUM_VOICES];
    logic [1:0]     mode_q       [NUM_VOICES];
    logic [1:0]     mode_d       [NUM_VOICES];
`ifdef WAVE_SHAPER_PWM_EN
    logic [W-1:0]   pw_snap_q    [NUM_VOICES];
    logic [W-1:0]   pw_snap_d    [NUM_VOICES];
`endif

    logic [W-1:0] cur_p;
    logic [W-1:0] thresh;
    logic [W-1:0] shaped;

    assign cur_p = phase_snap_q[idx_q];
`ifdef WAVE_SHAPER_PWM_EN
    assign thresh = pw_snap_q[idx_q];
`else
    assign thresh = HALF;
`endif

    always_comb begin
        shaped = '0;
        case (mode_q[idx_q])
            2'b01:   shaped = (cur_p < thresh) ? '0 : '1;
            2'b10:   shaped = cur_p;
            // Folding the doubled phase gives a triangle peaking at mid-phase.
            2'b11:   shaped = cur_p[W-1] ? ~{cur_p[W-2:0], 1'b0} : {cur_p[W-2:0], 1'b0};
            default: shaped = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        mix_d        = mix_q;
        valid_d      = 1'b0;
        phase_snap_d = phase_snap_q;
        prev_phase_d = prev_phase_q;
        mode_d       = mode_q;
`ifdef WAVE_SHAPER_PWM_EN
        pw_snap_d    = pw_snap_q;
`endif
        case (state_q)
            IDLE: if (bus.sample_req) state_d = LOAD;
            LOAD: begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    phase_snap_d[v] = bus.phase_in[v*W +: W];
                    // Mode switches only on wrap (or from off) so the output never clicks.
                    if (mode_q[v] == 2'b00 || bus.phase_in[v*W +: W] < prev_phase_q[v])
                        mode_d[v] = bus.wave_form[v*2 +: 2];
                    prev_phase_d[v] = bus.phase_in[v*W +: W];
`ifdef WAVE_SHAPER_PWM_EN
                    pw_snap_d[v] = bus.pulse_width[v*W +: W];
`endif
                end
                acc_d   = '0;
                idx_d   = '0;
                state_d = SHAPE;
            end
            SHAPE: begin
                acc_d = acc_q + ACW'(shaped);
                if (idx_q == LAST) begin
                    mix_d   = W'(acc_d >> LOG_V);
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + IDW'(1);
                end
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            mix_q   <= '0;
            valid_q <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_snap_q[v] <= '0;
                prev_phase_q[v] <= '0;
                mode_q[v]       <= 2'b00;
`ifdef WAVE_SHAPER_PWM_EN
                pw_snap_q[v]    <= '0;
`endif
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            mix_q        <= mix_d;
            valid_q      <= valid_d;
            phase_snap_q <= phase_snap_d;
            prev_phase_q <= prev_phase_d;
            mode_q       <= mode_d;
`ifdef WAVE_SHAPER_PWM_EN
            pw_snap_q    <= pw_snap_d;
`endif
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.sample_valid = valid_q;
    assign bus.mix_out      = mix_q;
    assign state_dbg_o      = state_q;
endmodule

// File: tb/tb_wave_shaper_mix.sv
// Self-checking bench for wave_shaper_mix (W=8, 4 voices) against a behavioural mixer model.
// Covers reset, directed shaping/latching cases, back-to-back requests and random traffic.
module tb_wave_shaper_mix;
    localparam int W = 8;
    localparam int N = 4;

    logic       clk;
    logic       n_rst;
    logic [1:0] state_dbg;
    int         n_cmp;
    int         n_fail;
    logic [W-1:0] exp_q [$];

    int mode_m [N];
    int prev_m [N];

    wave_shaper_mix_if #(.W(W), .NUM_VOICES(N)) bus ();

    wave_shaper_mix #(.W(W), .NUM_VOICES(N)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int shape_ref(int p, int m, int thr);
        case (m)
            0:       return 0;
            1:       return (p < thr) ? 0 : 255;
            2:       return p;
            default: return (p < 128) ? 2 * p : 511 - 2 * p;
        endcase
    endfunction

    task automatic model_step(input logic [N*W-1:0] ph, input logic [N*2-1:0] wf,
                              input logic [N*W-1:0] pw, output int mix);
        int sum, p, thr;
        sum = 0;
        for (int v = 0; v < N; v++) begin
            p = int'(ph[v*W +: W]);
`ifdef WAVE_SHAPER_PWM_EN
            thr = int'(pw[v*W +: W]);
`else
            thr = 128 + 0 * int'(pw[0]);
`endif
            if (mode_m[v] == 0 || p < prev_m[v]) mode_m[v] = int'(wf[v*2 +: 2]);
            prev_m[v] = p;
            sum += shape_ref(p, mode_m[v], thr);
        end
        mix = sum / N;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        bus.sample_req = 1'b0;
        for (int v = 0; v < N; v++) begin
            mode_m[v] = 0;
            prev_m[v] = 0;
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input logic [N*W-1:0] ph, input logic [N*2-1:0] wf, input logic [N*W-1:0] pw);
        bus.phase_in  = ph;
        bus.wave_form = wf;
`ifdef WAVE_SHAPER_PWM_EN
        bus.pulse_width = pw;
`endif
    endtask

    // One request; optionally scrambles inputs and pokes req while busy.
    task automatic do_sample(input string tag, input logic [N*W-1:0] ph, input logic [N*2-1:0] wf,
                             input logic [N*W-1:0] pw, input bit disturb, output int got);
        int exp_v, lat;
        bit seen;
        logic [W-1:0] e;
        @(negedge clk);
        drive(ph, wf, pw);
        bus.sample_req = 1'b1;
        model_step(ph, wf, pw, exp_v);
        exp_q.push_back(W'(exp_v));
        @(posedge clk);
        #1 bus.sample_req = 1'b0;
        check({tag, "_busy_load"}, int'(bus.busy), 1);
        @(posedge clk);
        #1;
        if (disturb) drive({$urandom, $urandom}, 8'($urandom), {$urandom, $urandom});
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (bus.sample_valid) seen = 1'b1;
            else begin
                bus.sample_req = (disturb && lat == 2);
                @(posedge clk);
                lat++;
            end
        end
        bus.sample_req = 1'b0;
        check({tag, "_valid_seen"}, int'(seen), 1);
        check({tag, "_latency"}, lat, 5);
        e = exp_q.pop_front();
        got = int'(bus.mix_out);
        check({tag, "_mix"}, got, int'(e));
        @(posedge clk);
        @(posedge clk);
        #1 check({tag, "_idle_after"}, int'(bus.busy), 0);
    endtask

    initial begin
        int got, nv, last_t;
        int vt [$];
        n_cmp = 0;
        n_fail = 0;
        n_rst = 1'b0;
        bus.sample_req = 1'b0;
        drive('0, '0, '0);
        for (int v = 0; v < N; v++) begin
            mode_m[v] = 0;
            prev_m[v] = 0;
        end
        #12;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.sample_valid), 0);
        check("rst_mix", int'(bus.mix_out), 0);
        check("rst_state", int'(state_dbg), 0);
        do_reset();

        // All saw: (8+16+32+64)/4 = 30
        do_sample("saw", {8'd64, 8'd32, 8'd16, 8'd8}, 8'b10_10_10_10, {4{8'd128}}, 1'b0, got);
        check("saw_const", got, 30);

        // Triangle on voice 0 only
        do_reset();
        do_sample("tri128", {24'd0, 8'd128}, 8'b00_00_00_11, {4{8'd128}}, 1'b0, got);
        check("tri128_const", got, 63);
        do_sample("tri255", {24'd0, 8'd255}, 8'b00_00_00_11, {4{8'd128}}, 1'b0, got);
        check("tri255_const", got, 0);
        do_sample("tri64", {24'd0, 8'd64}, 8'b00_00_00_11, {4{8'd128}}, 1'b0, got);
        check("tri64_const", got, 32);

        // Mode latches until phase wraps
        do_reset();
        do_sample("sq200", {24'd0, 8'd200}, 8'b00_00_00_01, {4{8'd128}}, 1'b0, got);
        check("sq200_const", got, 63);
        do_sample("hold200", {24'd0, 8'd200}, 8'b00_00_00_10, {4{8'd128}}, 1'b0, got);
        check("hold200_const", got, 63);
        do_sample("hold220", {24'd0, 8'd220}, 8'b00_00_00_10, {4{8'd128}}, 1'b0, got);
        check("hold220_const", got, 63);
        do_sample("wrap10", {24'd0, 8'd10}, 8'b00_00_00_10, {4{8'd128}}, 1'b0, got);
        check("wrap10_const", got, 2);

        // Square threshold edges
        do_reset();
`ifdef WAVE_SHAPER_PWM_EN
        do_sample("pw63", {24'd0, 8'd63}, 8'b00_00_00_01, {4{8'd64}}, 1'b0, got);
        check("pw63_const", got, 0);
        do_sample("pw64", {24'd0, 8'd64}, 8'b00_00_00_01, {4{8'd64}}, 1'b0, got);
        check("pw64_const", got, 63);
`else
        do_sample("th127", {24'd0, 8'd127}, 8'b00_00_00_01, {4{8'd64}}, 1'b0, got);
        check("th127_const", got, 0);
        do_sample("th128", {24'd0, 8'd128}, 8'b00_00_00_01, {4{8'd64}}, 1'b0, got);
        check("th128_const", got, 63);
`endif

        // Reset in the middle of SHAPE aborts the computation
        @(negedge clk);
        bus.sample_req = 1'b1;
        @(posedge clk);
        #1 bus.sample_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_valid", int'(bus.sample_valid), 0);
        check("midrst_mix", int'(bus.mix_out), 0);
        check("midrst_state", int'(state_dbg), 0);
        for (int v = 0; v < N; v++) begin
            mode_m[v] = 0;
            prev_m[v] = 0;
        end
        @(negedge clk);
        n_rst = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.sample_valid) nv++;
        end
        check("midrst_no_pulse", nv, 0);

        // Request held high: one sample every N+3 cycles
        do_reset();
        drive({8'd4, 8'd3, 8'd2, 8'd1}, 8'b10_10_10_10, {4{8'd128}});
        bus.sample_req = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.sample_valid) vt.push_back(i);
        end
        bus.sample_req = 1'b0;
        check("cont_count", vt.size(), 4);
        last_t = (vt.size() > 0) ? vt[0] : 0;
        check("cont_first", last_t, 6);
        for (int i = 1; i < vt.size(); i++) begin
            check("cont_period", vt[i] - last_t, N + 3);
            last_t = vt[i];
        end
        check("cont_mix", int'(bus.mix_out), 2);
        repeat (3) @(negedge clk);

        // Random traffic against the model
        do_reset();
        for (int t = 0; t < 40; t++) begin
            do_sample("rand", {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                      {$urandom, $urandom}, 1'($urandom_range(0, 1)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
